// File: rtl/mda_attr_sequencer.sv
// mda_attr_sequencer
//   Latches one character cell and shifts out 9 dots per cell. It applies the
//   MDA attribute rules: underline, reverse, non-display, intensity, character
//   blink and cursor blink. It also owns the frame counter that paces both
//   blink phases.
// Ports:
//   clk, reset_n        pixel clock, async active-low reset
//   pix_strobe          advance one dot
//   char_load           load a new cell (only together with pix_strobe)
//   glyph_row/char_code/attr/cursor_hit   cell contents captured at load
//   underline_row/display_enable/blink_enable   sampled live on every strobe
//   vsync               frame counter increments on its rising edge
//   video/intensity     registered dot outputs, 1 clk after the strobe
module mda_attr_sequencer #(
  parameter int CURSOR_BIT = 3,
  parameter int BLINK_BIT  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_strobe,
  input  logic       char_load,
  input  logic [7:0] glyph_row,
  input  logic [7:0] char_code,
  input  logic [7:0] attr,
  input  logic       cursor_hit,
  input  logic       underline_row,
  input  logic       display_enable,
  input  logic       blink_enable,
  input  logic       vsync,
  output logic       video,
  output logic       intensity
);

  localparam logic [3:0] DOT_IDLE = 4'd9;

  logic [7:0] glyph_q, code_q, attr_q;
  logic       cur_q;
  logic [3:0] dot_q;
  logic       video_q, inten_q;
  logic       vsync_q;
  logic [4:0] frame_q;

  logic [7:0] glyph_d, code_d, attr_d;
  logic       cur_d;
  logic [3:0] dot_d;
  logic       video_d, inten_d;
  logic [2:0] bit_idx;
  logic       fg, fg_eff;
  logic       nondisp, rev, uline;

  // The dot emitted on a strobe uses the post-strobe cell and dot index, so a
  // load shows dot 0 of the new cell immediately (no bubble).
  always_comb begin
    glyph_d = char_load ? glyph_row  : glyph_q;
    code_d  = char_load ? char_code  : code_q;
    attr_d  = char_load ? attr       : attr_q;
    cur_d   = char_load ? cursor_hit : cur_q;
    if (char_load)               dot_d = 4'd0;
    else if (dot_q >= DOT_IDLE)  dot_d = DOT_IDLE;
    else                         dot_d = dot_q + 4'd1;

    bit_idx = 3'd7 - dot_d[2:0];
    fg = 1'b0;
    if (dot_d < 4'd8)       fg = glyph_d[bit_idx];
    else if (dot_d == 4'd8) fg = (code_d[7:5] == 3'b110) & glyph_d[0];

    nondisp = (attr_d[6:4] == 3'd0) && (attr_d[2:0] == 3'd0);
    rev     = (attr_d[6:4] == 3'd7) && (attr_d[2:0] == 3'd0);
    uline   = (attr_d[6:4] == 3'd0) && (attr_d[2:0] == 3'd1) && underline_row;

    if (uline) fg = 1'b1;
    fg_eff = fg & ~(blink_enable & attr_d[7] & ~frame_q[BLINK_BIT]);

    video_d = 1'b0;
    inten_d = 1'b0;
    if (!display_enable || dot_d == DOT_IDLE) begin
      video_d = 1'b0;
      inten_d = 1'b0;
    end else if (cur_d && frame_q[CURSOR_BIT]) begin
      video_d = 1'b1;
      inten_d = attr_d[3];
    end else if (nondisp) begin
      video_d = 1'b0;
      inten_d = 1'b0;
    end else if (rev) begin
      // attr[7] acts as bright background only when blink is disabled
      video_d = ~fg_eff;
      inten_d = attr_d[7] & ~blink_enable & ~fg_eff;
    end else begin
      video_d = fg_eff;
      inten_d = attr_d[3] & fg_eff;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glyph_q <= '0;
      code_q  <= '0;
      attr_q  <= '0;
      cur_q   <= 1'b0;
      dot_q   <= DOT_IDLE;
      video_q <= 1'b0;
      inten_q <= 1'b0;
      vsync_q <= 1'b0;
      frame_q <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q) frame_q <= frame_q + 5'd1;
      if (pix_strobe) begin
        glyph_q <= glyph_d;
        code_q  <= code_d;
        attr_q  <= attr_d;
        cur_q   <= cur_d;
        dot_q   <= dot_d;
        video_q <= video_d;
        inten_q <= inten_d;
      end
    end
  end

  assign video     = video_q;
  assign intensity = inten_q;

endmodule

// File: tb/tb_mda_attr_sequencer.sv
module tb_mda_attr_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_strobe = 1'b0, char_load = 1'b0;
  logic [7:0] glyph_row = '0, char_code = '0, attr = '0;
  logic       cursor_hit = 1'b0, underline_row = 1'b0, display_enable = 1'b1;
  logic       blink_enable = 1'b0, vsync = 1'b0;
  logic       video, intensity;

  int n_pass = 0, n_total = 0;

  mda_attr_sequencer #(.CURSOR_BIT(3), .BLINK_BIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .pix_strobe(pix_strobe), .char_load(char_load),
    .glyph_row(glyph_row), .char_code(char_code), .attr(attr),
    .cursor_hit(cursor_hit), .underline_row(underline_row),
    .display_enable(display_enable), .blink_enable(blink_enable),
    .vsync(vsync), .video(video), .intensity(intensity)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] g, c, a;
    logic       cur, ul, de, be;
    logic [8:0] ev, ei;   // MSB = dot 0
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got video/int=%b want %b at %0t", nm, act, exp, $time);
  endtask

  // Load a cell and clock out its 9 dots, one strobe per cycle.
  task automatic run_cell(input string nm, input logic [7:0] g, c, a,
                          input logic cur, ul, de, be,
                          input logic [8:0] ev, ei);
    glyph_row = g; char_code = c; attr = a; cursor_hit = cur;
    underline_row = ul; display_enable = de; blink_enable = be;
    for (int d = 0; d < 9; d++) begin
      pix_strobe = 1'b1;
      char_load  = (d == 0);
      @(posedge clk); #1;
      check($sformatf("%s dot%0d", nm, d), {video, intensity}, {ev[8-d], ei[8-d]});
    end
    pix_strobe = 1'b0; char_load = 1'b0;
  endtask

  task automatic vsync_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1; @(posedge clk); #1;
      vsync = 1'b0; @(posedge clk); #1;
    end
  endtask

  // Reference: dot value straight from the attribute rules.
  function automatic logic [1:0] ref_dot(input logic [7:0] g, c, a, input logic cur,
                                         input int dot, input logic ul, de, be,
                                         input int frame);
    logic f, v, i;
    logic [2:0] bg, fc;
    if (!de || dot >= 9) return 2'b00;
    if (cur && frame[3]) return {1'b1, a[3]};
    bg = a[6:4]; fc = a[2:0];
    if (dot < 8) f = g[7-dot];
    else         f = (c[7:5] == 3'b110) ? g[0] : 1'b0;
    if (bg == 0 && fc == 1 && ul) f = 1'b1;
    if (be && a[7] && !frame[4]) f = 1'b0;
    if (bg == 0 && fc == 0)      begin v = 1'b0; i = 1'b0; end
    else if (bg == 7 && fc == 0) begin v = !f; i = a[7] && !be && v; end
    else                         begin v = f; i = a[3] && v; end
    return {v, i};
  endfunction

  initial begin
    tbl[0]  = '{"normal07",   8'hA5, 8'h41, 8'h07, 0, 0, 1, 0, 9'b101001010, 9'b000000000};
    tbl[1]  = '{"normal0F",   8'hA5, 8'h41, 8'h0F, 0, 0, 1, 0, 9'b101001010, 9'b101001010};
    tbl[2]  = '{"linedraw",   8'h01, 8'hC4, 8'h07, 0, 0, 1, 0, 9'b000000011, 9'b000000000};
    tbl[3]  = '{"noreplic",   8'h01, 8'h41, 8'h07, 0, 0, 1, 0, 9'b000000010, 9'b000000000};
    tbl[4]  = '{"reverse",    8'hF0, 8'h41, 8'h70, 0, 0, 1, 0, 9'b000011111, 9'b000000000};
    tbl[5]  = '{"nondisp00",  8'hFF, 8'h41, 8'h00, 0, 0, 1, 0, 9'b000000000, 9'b000000000};
    tbl[6]  = '{"nondisp88",  8'hFF, 8'h41, 8'h88, 0, 0, 1, 0, 9'b000000000, 9'b000000000};
    tbl[7]  = '{"underline",  8'h00, 8'h41, 8'h01, 0, 1, 1, 0, 9'b111111111, 9'b000000000};
    tbl[8]  = '{"blinkoff",   8'hA5, 8'h41, 8'h87, 0, 0, 1, 1, 9'b000000000, 9'b000000000};
    tbl[9]  = '{"revbright",  8'hF0, 8'h41, 8'hF0, 0, 0, 1, 0, 9'b000011111, 9'b000011111};
    tbl[10] = '{"de_off",     8'hA5, 8'h41, 8'h0F, 0, 0, 0, 0, 9'b000000000, 9'b000000000};
    tbl[11] = '{"cursor_f0",  8'hA5, 8'h41, 8'h0F, 1, 0, 1, 0, 9'b101001010, 9'b101001010};
    tbl[12] = '{"ul_row_off", 8'hA5, 8'h41, 8'h01, 0, 0, 1, 0, 9'b101001010, 9'b000000000};

    #12;
    check("reset", {video, intensity}, 2'b00);
    reset_n = 1'b1;
    @(posedge clk); #1;
    // Idle after reset: strobe without a load stays blank
    pix_strobe = 1'b1; @(posedge clk); #1; pix_strobe = 1'b0;
    check("idle_after_reset", {video, intensity}, 2'b00);

    foreach (tbl[k])
      run_cell(tbl[k].nm, tbl[k].g, tbl[k].c, tbl[k].a, tbl[k].cur, tbl[k].ul,
               tbl[k].de, tbl[k].be, tbl[k].ev, tbl[k].ei);

    // Strobe train of 12 after one load: dots 9..11 blank
    glyph_row = 8'hFF; char_code = 8'hC0; attr = 8'h07; cursor_hit = 0;
    underline_row = 0; display_enable = 1; blink_enable = 0;
    for (int d = 0; d < 12; d++) begin
      pix_strobe = 1'b1; char_load = (d == 0);
      @(posedge clk); #1;
      check($sformatf("train dot%0d", d), {video, intensity}, (d < 9) ? 2'b10 : 2'b00);
    end
    // Outputs hold between strobes
    pix_strobe = 1'b0; char_load = 1'b0;
    run_cell("hold_pre", 8'h00, 8'h41, 8'h01, 0, 1, 1, 0, 9'b111111111, 9'b0);
    underline_row = 0;
    repeat (3) @(posedge clk); #1;
    check("hold", {video, intensity}, 2'b10);

    // Reset asserted at dot 4
    glyph_row = 8'hFF; attr = 8'h0F; char_code = 8'h41;
    for (int d = 0; d < 5; d++) begin
      pix_strobe = 1'b1; char_load = (d == 0);
      @(posedge clk); #1;
    end
    check("dot4_before_reset", {video, intensity}, 2'b11);
    reset_n = 1'b0; #1;
    check("reset_mid_cell", {video, intensity}, 2'b00);
    #2 reset_n = 1'b1;
    char_load = 1'b0; pix_strobe = 1'b1;
    @(posedge clk); #1;
    check("after_reset_no_load", {video, intensity}, 2'b00);
    pix_strobe = 1'b0;

    // char_load without pix_strobe is ignored: still idle
    char_load = 1'b1; @(posedge clk); #1; char_load = 1'b0;
    pix_strobe = 1'b1; @(posedge clk); #1; pix_strobe = 1'b0;
    check("load_no_strobe", {video, intensity}, 2'b00);

    // Frames 8..15: cursor visible
    vsync_pulses(8);
    run_cell("cursor_f8", 8'hA5, 8'h41, 8'h0F, 1, 0, 1, 0, 9'h1FF, 9'h1FF);
    run_cell("cursor_de0", 8'hA5, 8'h41, 8'h0F, 1, 0, 0, 0, 9'h000, 9'h000);
    // Frame 16: cursor hidden, blinking char shown
    vsync_pulses(8);
    run_cell("cursor_f16", 8'hA5, 8'h41, 8'h0F, 1, 0, 1, 0, 9'b101001010, 9'b101001010);
    run_cell("blink_f16", 8'hA5, 8'h41, 8'h87, 0, 0, 1, 1, 9'b101001010, 9'b0);
    run_cell("revblink_f16", 8'hF0, 8'h41, 8'hF0, 0, 0, 1, 1, 9'b000011111, 9'b0);
    // Frame 32 wraps to 0: same phase as after reset
    vsync_pulses(16);
    run_cell("blink_wrap", 8'hA5, 8'h41, 8'h87, 0, 0, 1, 1, 9'b0, 9'b0);
    run_cell("revblink_wrap", 8'hF0, 8'h41, 8'hF0, 0, 0, 1, 1, 9'h1FF, 9'b0);
    run_cell("cursor_wrap", 8'hA5, 8'h41, 8'h0F, 1, 0, 1, 0, 9'b101001010, 9'b101001010);

    // Randomized run against the reference
    begin
      logic [7:0] mg, mc, ma;
      logic       mcur, vprev;
      int         mdot, mframe;
      logic [1:0] mexp;
      mg = 0; mc = 0; ma = 0; mcur = 0; mdot = 9; mframe = 0; vprev = 0; mexp = 0;
      for (int n = 0; n < 3000; n++) begin
        pix_strobe     = (n == 0) || ($urandom_range(0, 3) != 0);
        char_load      = (n == 0) || ($urandom_range(0, 5) == 0);
        glyph_row      = 8'($urandom);
        char_code      = ($urandom_range(0, 1) == 1) ? 8'hC0 | 8'($urandom_range(0, 31)) : 8'($urandom);
        attr           = 8'($urandom);
        cursor_hit     = ($urandom_range(0, 3) == 0);
        underline_row  = ($urandom_range(0, 2) == 0);
        display_enable = ($urandom_range(0, 7) != 0);
        blink_enable   = $urandom_range(0, 1) == 1;
        vsync          = ($urandom_range(0, 5) == 0);
        if (pix_strobe) begin
          if (char_load) begin
            mg = glyph_row; mc = char_code; ma = attr; mcur = cursor_hit; mdot = 0;
          end else if (mdot < 9) mdot++;
          mexp = ref_dot(mg, mc, ma, mcur, mdot, underline_row, display_enable,
                         blink_enable, mframe);
        end
        if (vsync && !vprev) mframe = (mframe + 1) % 32;
        vprev = vsync;
        @(posedge clk); #1;
        check($sformatf("rand%0d", n), {video, intensity}, mexp);
      end
      pix_strobe = 0; char_load = 0; vsync = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mda_attr_sequencer.md
# mda_attr_sequencer

Character-to-dot sequencer feeding the MDA VGA colour port. It latches one character cell (glyph row, character code, attribute, cursor flag), shifts out 9 dots per cell, and applies MDA attribute rules: underline, reverse, non-display, intensity, character blink and cursor blink. It drives the `video`/`intensity` pair consumed by the VGA palette stage. It owns the frame-rate blink counters.

## Interface
Parameters:
- CURSOR_BIT, 3, frame_cnt bit giving cursor-blink phase (16-frame period)
- BLINK_BIT, 4, frame_cnt bit giving character-blink phase (32-frame period)

Ports:
- clk  in  1  pixel-domain clock
- reset_n  in  1  asynchronous, active-low reset
- pix_strobe  in  1  dot enable; one dot advanced per strobe
- char_load  in  1  load new cell; only honoured together with pix_strobe
- glyph_row  in  8  font row bits, bit 7 = leftmost dot
- char_code  in  8  character code (for 9th-dot replication)
- attr  in  8  MDA attribute byte
- cursor_hit  in  1  cell is the cursor position on a cursor scanline
- underline_row  in  1  current scanline is the underline row
- display_enable  in  1  active display area
- blink_enable  in  1  mode register blink bit (1: attr[7] = blink, 0: attr[7] = bright background)
- vsync  in  1  vertical sync, active high
- video  out  1  dot on
- intensity  out  1  dot bright

## Operation
- Cell load (pix_strobe & char_load): latch glyph_row, char_code, attr, cursor_hit into cell registers; dot_cnt <= 0; the dot emitted on this strobe is dot 0 of the new cell.
- Strobe without load: dot_cnt increments, saturating at 9. dot_cnt = 9 means idle, and the emitted dot is blank (video=0, intensity=0).
- Raw foreground fg: dots 0..7 = glyph bit (7 - dot_cnt). Dot 8 = glyph bit 0 if char_code[7:5] == 3'b110, else 0.
- Attribute classes, evaluated on latched attr; bg = attr[6:4], fc = attr[2:0]:
  - non-display: bg == 0 and fc == 0 → fg forced 0
  - reverse: bg == 7 and fc == 0 → video = ~fg_eff
  - underline: bg == 0 and fc == 1 and underline_row → fg forced 1 on all 9 dots
  - otherwise normal: video = fg_eff
- Character blink: fg_eff = fg & ~(blink_enable & attr[7] & ~frame_cnt[BLINK_BIT]). Blink suppresses the foreground only; in reverse the cell shows solid background.
- Intensity:
  - Normal and underline: intensity = attr[3] & video.
  - Reverse: intensity = attr[7] & ~blink_enable & video.
- Cursor: latched cursor_hit & frame_cnt[CURSOR_BIT] → video = 1 and intensity = attr[3] on all 9 dots. Cursor has priority over every attribute class.
- display_enable = 0 on a strobe → blank dot. Highest priority, above cursor.
- underline_row, display_enable and blink_enable are sampled live on each strobe, not latched at load.
- Frame counter: 5-bit frame_cnt increments on each vsync rising edge, detected against a registered copy of vsync. Wraps 31 → 0. Independent of pix_strobe.

## Timing
- Reset (asynchronous assert): video=0, intensity=0, frame_cnt=0, vsync_q=0, dot_cnt=9 (idle), cell registers 0.
- Reset release takes effect on the first clk edge after deassertion. Reset mid-cell discards the cell; the output stays blank until the next char_load.
- video/intensity are registered and update only on pix_strobe cycles; they hold between strobes. Latency is 1 clk from the strobe to the dot appearing at the outputs.
- Back-to-back cells: a char_load at dot_cnt = 8 is the normal case. A char_load at any dot_cnt truncates the current cell with no bubble.
- char_load without pix_strobe is ignored.
- vsync edge and pix_strobe in the same cycle: the dot is computed with the pre-increment frame_cnt. The new blink phase takes effect on the next strobe.
- Blink phases: cursor visible for 8 of every 16 frames; blinking characters visible for 16 of every 32 frames. Both start invisible after reset (frame_cnt = 0).

## Test plan
- Normal cell: attr=0x07, glyph=0xA5, code=0x41, strobes every cycle → video 1,0,1,0,0,1,0,1,0 over dots 0..8; intensity 0 throughout. attr=0x0F → intensity follows video.
- Line-draw replication: code=0xC4, glyph=0x01 → dot 7 = 1 and dot 8 = 1. Same glyph with code=0x41 → dot 8 = 0.
- Attribute classes:
  - attr=0x70, glyph=0xF0 → video 0,0,0,0,1,1,1,1,1
  - attr=0x00 or 0x88 → all 9 dots 0
  - attr=0x01 with underline_row=1 → all 9 dots 1
- Blink: attr=0x87, blink_enable=1, 16 vsync pulses from reset → dots 0 for frames 0–15 and glyph for frames 16–31. With blink_enable=0 and attr=0xF0 → intensity=1 on lit reverse dots.
- Cursor: cursor_hit=1, attr=0x0F → video=1 and intensity=1 on all dots in frames 8–15, glyph pattern in frames 0–7. display_enable=0 blanks the cell even with the cursor visible.
- Boundaries:
  - Strobe train of 12 after a single load → dots 9–11 blank.
  - Reset asserted at dot 4 → outputs 0 immediately.
  - 32 vsync edges → frame_cnt returns to 0, phase matches post-reset.
